uart_tx: RTL and testbench

Serial transmitter for the UART IP: accepts one parallel byte per valid/ready handshake and shifts it out on a single line as an asynchronous 8N1 frame (8N2 optional). It is the output side of the UART IP: debounced button events and AXI register writes feed bytes into it, and it drives the physical TX pin. The output bit timing comes from an internal baud counter on the single system clock. No fractional-baud support.

---
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter: accepts a byte on tx_valid & tx_ready, first start-bit clock follows the accepting edge.
// Frame takes (9+STOP_BITS)*CLKS_PER_BIT cycles; tx_ready stays low until the last stop bit ends.
module uart_tx #(
  parameter int CLKS_PER_BIT = 52,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // The line level for the next bit is registered on the same edge that ends the
  // current bit, so tx never has a combinational path from any input.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          baud_d  = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = ~ready_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance 8N1, one 8N2, both at 4 clocks per bit.
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int F1  = 10 * CPB;
  localparam int F2  = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic       tx_ready2, tx2, tx_busy2, tx_done2;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  logic       rdy_prev = 1'b0;
  int         acc_q[$];
  int         done_cnt = 0;
  logic [7:0] rx_q[$];
  logic       rx_stop_q[$];
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  // Acceptance log: valid at the edge while ready was seen high in the preceding low phase.
  always @(posedge clk) begin
    cyc++;
    if (!rst && tx_valid && rdy_prev === 1'b1) acc_q.push_back(cyc);
  end

  // Receiver model sampling mid-bit, plus tx_done pulse counter.
  always @(negedge clk) begin
    rdy_prev = tx_ready;
    if (tx_done === 1'b1) done_cnt++;
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= CPB && mon_cnt < 9 * CPB && (mon_cnt % CPB) == CPB / 2)
        mon_byte[3'(mon_cnt / CPB - 1)] = tx;
      if (mon_cnt == 9 * CPB + CPB / 2) begin
        rx_q.push_back(mon_byte);
        rx_stop_q.push_back(tx);
        mon_active = 1'b0;
      end
    end
  end

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL reset_async_tx got %b exp 1", tx); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_async_ready got %b exp 1", tx_ready); end
    n_checks++; if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_async_busy got %b exp 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0)  begin n_fail++; $display("FAIL reset_async_done got %b exp 0", tx_done); end
    n_checks++; if (tx2 !== 1'b1 || tx_ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_async_dut2 got tx=%b rdy=%b exp 1/1", tx2, tx_ready2); end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold got tx=%b rdy=%b busy=%b done=%b exp 1 1 0 0", tx, tx_ready, tx_busy, tx_done);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_byte();
    bit exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int d0, a0, r0;
    d0 = done_cnt; a0 = acc_q.size(); r0 = rx_q.size();
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'hA5;
    @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'h00;
    for (int j = 0; j <= F1 + 1; j++) begin
      @(negedge clk);
      if (j < F1) begin
        n_checks++; if (tx !== exp_bits[j / CPB]) begin n_fail++; $display("FAIL single_tx j=%0d got %b exp %b", j, tx, exp_bits[j / CPB]); end
      end
      n_checks++; if (tx_done !== (j == F1)) begin n_fail++; $display("FAIL single_done j=%0d got %b exp %b", j, tx_done, (j == F1)); end
      if (j == 0) begin
        n_checks++; if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got rdy=%b busy=%b exp 0 1", tx_ready, tx_busy); end
      end
      if (j == F1) begin
        n_checks++; if (tx_ready !== 1'b1 || tx !== 1'b1) begin n_fail++; $display("FAIL single_end got rdy=%b tx=%b exp 1 1", tx_ready, tx); end
      end
    end
    #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done_count got %0d exp 1", done_cnt - d0); end
    n_checks++; if (acc_q.size() - a0 != 1) begin n_fail++; $display("FAIL single_accepts got %0d exp 1", acc_q.size() - a0); end
    n_checks++; if (rx_q.size() != r0 + 1 || rx_q[r0] !== 8'hA5) begin n_fail++; $display("FAIL single_rx got n=%0d exp byte a5", rx_q.size() - r0); end
  endtask

  task automatic test_back_to_back();
    int d0, a0, r0;
    d0 = done_cnt; a0 = acc_q.size(); r0 = rx_q.size();
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h00;
    @(posedge clk);
    for (int j = 0; j <= F1 + 1; j++) begin
      @(negedge clk);
      if (j == 0) tx_data = 8'hFF;
      if (j == F1 - 1) begin
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_stop got %b exp 1", tx); end
      end
      if (j == F1) begin
        n_checks++; if (tx !== 1'b1 || tx_done !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got tx=%b done=%b exp 1 1", tx, tx_done); end
      end
      if (j == F1 + 1) begin
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start2 got %b exp 0", tx); end
        tx_valid = 1'b0;
      end
    end
    repeat (F1 + 5) @(negedge clk);
    #1;
    n_checks++; if (acc_q.size() - a0 != 2) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 2", acc_q.size() - a0); end
    else begin
      n_checks++; if (acc_q[a0 + 1] - acc_q[a0] != F1 + 1) begin n_fail++; $display("FAIL b2b_period got %0d exp %0d", acc_q[a0 + 1] - acc_q[a0], F1 + 1); end
    end
    n_checks++; if (rx_q.size() != r0 + 2) begin n_fail++; $display("FAIL b2b_rx_count got %0d exp 2", rx_q.size() - r0); end
    else begin
      n_checks++; if (rx_q[r0] !== 8'h00) begin n_fail++; $display("FAIL b2b_rx0 got %h exp 00", rx_q[r0]); end
      n_checks++; if (rx_q[r0 + 1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_rx1 got %h exp ff", rx_q[r0 + 1]); end
      n_checks++; if (rx_stop_q[r0] !== 1'b1 || rx_stop_q[r0 + 1] !== 1'b1) begin n_fail++; $display("FAIL b2b_stop_bits got %b%b exp 11", rx_stop_q[r0], rx_stop_q[r0 + 1]); end
    end
    n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt - d0); end
  endtask

  task automatic test_input_isolation();
    int d0, a0, r0, bad_busy;
    d0 = done_cnt; a0 = acc_q.size(); r0 = rx_q.size(); bad_busy = 0;
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h3C;
    @(posedge clk);
    for (int j = 0; j <= F1 + 4; j++) begin
      @(negedge clk);
      if (j < F1 && tx_busy !== 1'b1) bad_busy++;
      if (j < 34) begin
        tx_valid = ~tx_valid;
        tx_data  = 8'($urandom_range(0, 255));
      end else begin
        tx_valid = 1'b0;
      end
    end
    #1;
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL iso_busy got %0d idle cycles exp 0", bad_busy); end
    n_checks++; if (acc_q.size() - a0 != 1) begin n_fail++; $display("FAIL iso_accepts got %0d exp 1", acc_q.size() - a0); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL iso_done_count got %0d exp 1", done_cnt - d0); end
    n_checks++; if (rx_q.size() != r0 + 1 || rx_q[r0] !== 8'h3C) begin n_fail++; $display("FAIL iso_rx got n=%0d exp byte 3c", rx_q.size() - r0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0, a0, r0, c0;
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h00;
    @(posedge clk); #1 tx_valid = 1'b0;
    d0 = done_cnt;
    repeat (18) @(negedge clk);
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3 got %b exp 0", tx); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abort got tx=%b rdy=%b busy=%b done=%b exp 1 1 0 0", tx, tx_ready, tx_busy, tx_done);
    end
    repeat (3) @(posedge clk);
    a0 = acc_q.size(); r0 = rx_q.size();
    #1 rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h81; c0 = cyc;
    @(posedge clk); #1 tx_valid = 1'b0;
    for (int j = 0; j <= F1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_start got %b exp 0", tx); end
      end
      if (j == F1 - 1 || j == F1) begin
        n_checks++; if (tx_done !== (j == F1)) begin n_fail++; $display("FAIL rstmid_done j=%0d got %b exp %b", j, tx_done, (j == F1)); end
      end
    end
    #1;
    n_checks++; if (acc_q.size() != a0 + 1 || acc_q[a0] != c0 + 1) begin n_fail++; $display("FAIL rstmid_accept_edge got n=%0d exp first edge after release", acc_q.size() - a0); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rstmid_done_count got %0d exp 1", done_cnt - d0); end
    n_checks++; if (rx_q.size() != r0 + 1 || rx_q[r0] !== 8'h81) begin n_fail++; $display("FAIL rstmid_rx got n=%0d exp byte 81", rx_q.size() - r0); end
  endtask

  task automatic test_two_stop_bits();
    bit exp2 [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int stop_hi;
    stop_hi = 0;
    @(posedge clk); #1 tx_valid2 = 1'b1; tx_data2 = 8'h55;
    @(posedge clk); #1 tx_valid2 = 1'b0;
    for (int j = 0; j <= F2 + 1; j++) begin
      @(negedge clk);
      if (j < 9 * CPB) begin
        n_checks++; if (tx2 !== exp2[j / CPB]) begin n_fail++; $display("FAIL stop2_tx j=%0d got %b exp %b", j, tx2, exp2[j / CPB]); end
      end else if (j < F2 && tx2 === 1'b1) begin
        stop_hi++;
      end
      n_checks++; if (tx_done2 !== (j == F2)) begin n_fail++; $display("FAIL stop2_done j=%0d got %b exp %b", j, tx_done2, (j == F2)); end
      if (j == F2 - 1) begin
        n_checks++; if (tx_ready2 !== 1'b0) begin n_fail++; $display("FAIL stop2_ready_early got %b exp 0", tx_ready2); end
      end
      if (j == F2) begin
        n_checks++; if (tx_ready2 !== 1'b1) begin n_fail++; $display("FAIL stop2_ready got %b exp 1", tx_ready2); end
      end
    end
    n_checks++; if (stop_hi != 2 * CPB) begin n_fail++; $display("FAIL stop2_len got %0d exp %0d", stop_hi, 2 * CPB); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_input_isolation();
    test_reset_mid_frame();
    test_two_stop_bits();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
